// File: rtl/xm_pkg.sv
`default_nettype none
// ============================================================================
// xm_pkg : shared op codes, flag indices and byte-lane encoding (X-Makina)
// Rev 1.0
// ============================================================================
package xm_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADDC = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SUBC = 4'd3,
    ALU_DADD = 4'd4,
    ALU_CMP  = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_AND  = 4'd7,
    ALU_BIT  = 4'd8,
    ALU_BIC  = 4'd9,
    ALU_BIS  = 4'd10,
    ALU_MOV  = 4'd11,
    ALU_SRA  = 4'd12,
    ALU_RRC  = 4'd13,
    ALU_SWPB = 4'd14,
    ALU_SXT  = 4'd15
  } alu_op_e;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

  localparam logic [1:0] DSEL_WORD = 2'd0;
  localparam logic [1:0] DSEL_LO   = 2'd1;
  localparam logic [1:0] DSEL_HI   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/xm_exec_addr_unit_if.sv
`default_nettype none
// ============================================================================
// xm_exec_addr_unit_if : operand, result, PC and address bundle of the unit
// Rev 1.0
// ============================================================================
interface xm_exec_addr_unit_if #(
  parameter int WORD = 16
);

  logic            byteOp_i;
  logic [3:0]      aluOp_i;
  logic            bcd_i;
  logic [WORD-1:0] a_i;
  logic [WORD-1:0] b_i;
  logic            flagsWr_i;
  logic [3:0]      flagsEn_i;
  logic [WORD-1:0] res_o;
  logic            resWr_o;
  logic [3:0]      aluFlags_o;
  logic [3:0]      flags_o;
  logic            pcSel_i;
  logic [WORD-1:0] branch_i;
  logic [WORD-1:0] pc_i;
  logic [WORD-1:0] pcNew_o;
  logic [WORD-1:0] adr_i;
  logic            badMem_o;
  logic            pswAddr_o;
  logic [1:0]      datSel_o;

  modport master (
    output byteOp_i, aluOp_i, bcd_i, a_i, b_i, flagsWr_i, flagsEn_i,
           pcSel_i, branch_i, pc_i, adr_i,
    input  res_o, resWr_o, aluFlags_o, flags_o, pcNew_o,
           badMem_o, pswAddr_o, datSel_o
  );

  modport slave (
    input  byteOp_i, aluOp_i, bcd_i, a_i, b_i, flagsWr_i, flagsEn_i,
           pcSel_i, branch_i, pc_i, adr_i,
    output res_o, resWr_o, aluFlags_o, flags_o, pcNew_o,
           badMem_o, pswAddr_o, datSel_o
  );

endinterface
`default_nettype wire

// File: rtl/xm_alu_core.sv
`default_nettype none
// ============================================================================
// xm_alu_core : combinational W-bit ALU with {V,N,Z,C} flags
// Decimal add on op 4 only when XM_ALU_BCD_EN is defined. Rev 1.0
// ============================================================================
module xm_alu_core
  import xm_pkg::*;
#(
  parameter int W = 16
) (
  input  alu_op_e      i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  input  logic         i_bcd,
  output logic [W-1:0] o_res,
  output logic [3:0]   o_flags
);

  logic         w_sub;
  logic         w_cin_eff;
  logic [W-1:0] w_b_opnd;
  logic [W:0]   w_sum;
  logic         w_sum_v;
  logic         w_use_bcd;
  logic [W-1:0] w_bcd_res;
  logic         w_bcd_c;
  logic [W-1:0] w_res;
  logic         w_c;
  logic         w_v;

  // Subtraction is a + ~b + carry-in, so C = 1 means no borrow
  always_comb begin
    w_sub    = (i_op == ALU_SUB) || (i_op == ALU_SUBC) || (i_op == ALU_CMP);
    w_b_opnd = w_sub ? ~i_b : i_b;
    case (i_op)
      ALU_SUB, ALU_CMP:              w_cin_eff = 1'b1;
      ALU_ADDC, ALU_SUBC, ALU_DADD:  w_cin_eff = i_cin;
      default:                       w_cin_eff = 1'b0;
    endcase
  end

  assign w_sum   = {1'b0, i_a} + {1'b0, w_b_opnd} + {{W{1'b0}}, w_cin_eff};
  assign w_sum_v = (i_a[W-1] == w_b_opnd[W-1]) && (w_sum[W-1] != i_a[W-1]);

`ifdef XM_ALU_BCD_EN
  localparam int NDIG = W / 4;
  localparam int TAIL = W - 4 * NDIG;

  logic [4*NDIG-1:0] w_bcd_lo;
  logic              w_bcd_lo_c;

  always_comb begin : p_bcd
    logic [4:0] w_dig;
    logic       w_dc;
    w_dc     = i_cin;
    w_dig    = '0;
    w_bcd_lo = '0;
    for (int d = 0; d < NDIG; d++) begin
      w_dig = {1'b0, i_a[4*d +: 4]} + {1'b0, i_b[4*d +: 4]} + {4'b0, w_dc};
      w_dc  = (w_dig > 5'd9);
      if (w_dc) w_dig = w_dig + 5'd6;
      w_bcd_lo[4*d +: 4] = w_dig[3:0];
    end
    w_bcd_lo_c = w_dc;
  end

  // A leftover 2-bit slice above the last full digit adds in binary
  if (TAIL != 0) begin : g_bcd_tail
    logic [TAIL:0] w_tail;
    assign w_tail    = {1'b0, i_a[W-1 -: TAIL]} + {1'b0, i_b[W-1 -: TAIL]}
                     + {{TAIL{1'b0}}, w_bcd_lo_c};
    assign w_bcd_res = {w_tail[TAIL-1:0], w_bcd_lo};
    assign w_bcd_c   = w_tail[TAIL];
  end else begin : g_bcd_notail
    assign w_bcd_res = w_bcd_lo;
    assign w_bcd_c   = w_bcd_lo_c;
  end

  assign w_use_bcd = i_bcd;
`else
  logic w_unused_bcd;
  assign w_unused_bcd = i_bcd;
  assign w_use_bcd    = 1'b0;
  assign w_bcd_res    = '0;
  assign w_bcd_c      = 1'b0;
`endif

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (i_op)
      ALU_ADD, ALU_ADDC, ALU_SUB, ALU_SUBC, ALU_CMP: begin
        w_res = w_sum[W-1:0];
        w_c   = w_sum[W];
        w_v   = w_sum_v;
      end
      ALU_DADD: begin
        if (w_use_bcd) begin
          w_res = w_bcd_res;
          w_c   = w_bcd_c;
        end else begin
          w_res = w_sum[W-1:0];
          w_c   = w_sum[W];
          w_v   = w_sum_v;
        end
      end
      ALU_XOR:        w_res = i_a ^ i_b;
      ALU_AND, ALU_BIT: w_res = i_a & i_b;
      ALU_BIC:        w_res = i_a & ~i_b;
      ALU_BIS:        w_res = i_a | i_b;
      ALU_MOV:        w_res = i_b;
      ALU_SRA: begin
        w_res = {i_a[W-1], i_a[W-1:1]};
        w_c   = i_a[0];
      end
      ALU_RRC: begin
        w_res = {i_cin, i_a[W-1:1]};
        w_c   = i_a[0];
      end
      ALU_SWPB:       w_res = {i_a[W/2-1:0], i_a[W-1:W/2]};
      ALU_SXT: begin
        w_res = i_a;
        for (int k = 8; k < W; k++) w_res[k] = i_a[7];
      end
      default:        w_res = '0;
    endcase
  end

  always_comb begin
    o_res           = w_res;
    o_flags         = '0;
    o_flags[FLAG_C] = w_c;
    o_flags[FLAG_Z] = (w_res == '0);
    o_flags[FLAG_N] = w_res[W-1];
    o_flags[FLAG_V] = w_v;
  end

endmodule
`default_nettype wire

// File: rtl/xm_exec_addr_unit.sv
`default_nettype none
// ============================================================================
// xm_exec_addr_unit : ALU + flags register, next-PC select, address decode
// Optional decimal add enabled by XM_ALU_BCD_EN. Rev 1.0
// ============================================================================
module xm_exec_addr_unit
  import xm_pkg::*;
#(
  parameter int              WORD     = 16,
  parameter logic [WORD-1:0] PSW_ADDR = WORD'(16'hFFFC)
) (
  input  logic              clk_i,
  input  logic              arst_i,
  xm_exec_addr_unit_if.slave bus
);

  alu_op_e         w_op;
  logic [WORD-1:0] w_word_res;
  logic [3:0]      w_word_fl;
  logic [7:0]      w_byte_res;
  logic [3:0]      w_byte_fl;
  logic            w_use_byte;
  logic [3:0]      w_alu_fl;
  logic [3:0]      r_flags;

  assign w_op = alu_op_e'(bus.aluOp_i);

  xm_alu_core #(.W(WORD)) u_word_alu (
    .i_op    (w_op),
    .i_a     (bus.a_i),
    .i_b     (bus.b_i),
    .i_cin   (r_flags[FLAG_C]),
    .i_bcd   (bus.bcd_i),
    .o_res   (w_word_res),
    .o_flags (w_word_fl)
  );

  xm_alu_core #(.W(8)) u_byte_alu (
    .i_op    (w_op),
    .i_a     (bus.a_i[7:0]),
    .i_b     (bus.b_i[7:0]),
    .i_cin   (r_flags[FLAG_C]),
    .i_bcd   (bus.bcd_i),
    .o_res   (w_byte_res),
    .o_flags (w_byte_fl)
  );

  // SWPB and SXT are inherently word operations whatever byteOp_i says
  assign w_use_byte     = bus.byteOp_i && (w_op != ALU_SWPB) && (w_op != ALU_SXT);
  assign w_alu_fl       = w_use_byte ? w_byte_fl : w_word_fl;
  assign bus.res_o      = w_use_byte ? WORD'(w_byte_res) : w_word_res;
  assign bus.aluFlags_o = w_alu_fl;
  assign bus.resWr_o    = !((w_op == ALU_CMP) || (w_op == ALU_BIT));

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_flags <= '0;
    end else if (bus.flagsWr_i) begin
      r_flags <= (r_flags & ~bus.flagsEn_i) | (w_alu_fl & bus.flagsEn_i);
    end
  end

  assign bus.flags_o = r_flags;

  assign bus.pcNew_o = bus.pc_i + (bus.pcSel_i ? bus.branch_i : WORD'(2));

  assign bus.badMem_o  = ~bus.byteOp_i & bus.adr_i[0];
  assign bus.pswAddr_o = (bus.adr_i[WORD-1:1] == PSW_ADDR[WORD-1:1]);
  assign bus.datSel_o  = !bus.byteOp_i ? DSEL_WORD :
                         (bus.adr_i[0] ? DSEL_HI : DSEL_LO);

endmodule
`default_nettype wire

// File: tb/tb_xm_exec_addr_unit.sv
`default_nettype none
// ============================================================================
// tb_xm_exec_addr_unit : directed + randomized scoreboard bench
// Rev 1.0
// ============================================================================
module tb_xm_exec_addr_unit;

  localparam int WORD = 16;
`ifdef XM_ALU_BCD_EN
  localparam bit BCD_ON = 1'b1;
`else
  localparam bit BCD_ON = 1'b0;
`endif

  logic clk_i  = 1'b0;
  logic arst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  xm_exec_addr_unit_if #(.WORD(WORD)) bus ();

  xm_exec_addr_unit #(.WORD(WORD), .PSW_ADDR(16'hFFFC)) dut (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .bus    (bus)
  );

  typedef struct {
    string       tag;
    logic [15:0] res;
    logic        res_wr;
    logic [3:0]  alu_fl;
    logic [3:0]  fl;
    logic [15:0] pc;
    logic        bad;
    logic        psw;
    logic [1:0]  dsel;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  logic       prev_wr = 1'b0;
  logic [3:0] prev_en = 4'b0;
  logic [3:0] prev_af = 4'b0;
  logic [3:0] m_flags = 4'b0;

  // ---------------- reference model (plain integer arithmetic) ----------------
  function automatic longint sgn(input longint unsigned x, input int n);
    if (((x >> (n - 1)) & 64'd1) != 0) return longint'(x) - (longint'(1) << n);
    return longint'(x);
  endfunction

  function automatic bit ovf(input longint s, input int n);
    return (s < -(longint'(1) << (n - 1))) || (s > (longint'(1) << (n - 1)) - 1);
  endfunction

  function automatic longint unsigned bcd2int(input longint unsigned x, input int ndig);
    longint unsigned v = 0;
    for (int d = ndig - 1; d >= 0; d--) v = v * 10 + ((x >> (4 * d)) & 64'd15);
    return v;
  endfunction

  function automatic longint unsigned int2bcd(input longint unsigned x, input int ndig);
    longint unsigned v = 0;
    longint unsigned t = x;
    for (int d = 0; d < ndig; d++) begin
      v = v | ((t % 10) << (4 * d));
      t = t / 10;
    end
    return v;
  endfunction

  task automatic ref_alu(input int op, input bit byte_m, input bit bcd,
                         input logic [15:0] a_in, input logic [15:0] b_in, input bit cin,
                         output logic [15:0] res, output logic [3:0] fl);
    int n;
    longint unsigned mask, a, b, r, full, ci, lim, dsum;
    longint s;
    bit c, v, sub;
    n    = (byte_m && op != 14 && op != 15) ? 8 : 16;
    mask = (64'd1 << n) - 1;
    a    = 64'(a_in) & mask;
    b    = 64'(b_in) & mask;
    r = 0; c = 1'b0; v = 1'b0;
    if (op == 4 && bcd && BCD_ON) begin
      lim = 1;
      for (int d = 0; d < n / 4; d++) lim = lim * 10;
      dsum = bcd2int(a, n / 4) + bcd2int(b, n / 4) + 64'(cin);
      c    = (dsum >= lim);
      r    = int2bcd(dsum % lim, n / 4);
    end else begin
      case (op)
        0, 1, 2, 3, 4, 5: begin
          sub  = (op == 2 || op == 3 || op == 5);
          ci   = (op == 0) ? 64'd0 : ((op == 2 || op == 5) ? 64'd1 : 64'(cin));
          full = a + (sub ? (~b & mask) : b) + ci;
          r    = full & mask;
          c    = ((full >> n) & 64'd1) != 0;
          s    = sgn(a, n) + (sub ? (-sgn(b, n) - 1) : sgn(b, n)) + longint'(ci);
          v    = ovf(s, n);
        end
        6:     r = a ^ b;
        7, 8:  r = a & b;
        9:     r = a & ~b & mask;
        10:    r = a | b;
        11:    r = b;
        12: begin r = (a >> 1) | (a & (64'd1 << (n - 1))); c = (a & 64'd1) != 0; end
        13: begin r = (a >> 1) | (64'(cin) << (n - 1));     c = (a & 64'd1) != 0; end
        14:    r = ((a & 64'hFF) << 8) | (a >> 8);
        default: r = ((a & 64'h80) != 0) ? ((a & 64'hFF) | 64'hFF00) : (a & 64'hFF);
      endcase
    end
    res = 16'(r);
    fl  = {v, (((r >> (n - 1)) & 64'd1) != 0), (r == 0), c};
  endtask

  // ---------------- stimulus: drive one vector, push expectation ----------------
  task automatic apply(input string tag, input int op, input bit byte_m, input bit bcd,
                       input logic [15:0] a, input logic [15:0] b,
                       input bit fwr, input logic [3:0] fen,
                       input bit psel, input logic [15:0] br, input logic [15:0] pc,
                       input logic [15:0] adr, input bit mid_reset);
    exp_t e;
    logic [15:0] r;
    logic [3:0]  af;
    @(posedge clk_i);
    #1;
    arst_i = 1'b1;
    if (prev_wr) m_flags = (m_flags & ~prev_en) | (prev_af & prev_en);
    bus.aluOp_i   = 4'(op);
    bus.byteOp_i  = byte_m;
    bus.bcd_i     = bcd;
    bus.a_i       = a;
    bus.b_i       = b;
    bus.flagsWr_i = fwr;
    bus.flagsEn_i = fen;
    bus.pcSel_i   = psel;
    bus.branch_i  = br;
    bus.pc_i      = pc;
    bus.adr_i     = adr;
    if (mid_reset) begin
      #2;
      arst_i  = 1'b0;
      m_flags = 4'b0;
    end
    ref_alu(op, byte_m, bcd, a, b, m_flags[0], r, af);
    e.tag    = tag;
    e.res    = r;
    e.res_wr = !(op == 5 || op == 8);
    e.alu_fl = af;
    e.fl     = m_flags;
    e.pc     = psel ? 16'(pc + br) : 16'(pc + 16'd2);
    e.bad    = !byte_m && adr[0];
    e.psw    = (adr == 16'hFFFC) || (adr == 16'hFFFD);
    e.dsel   = !byte_m ? 2'd0 : (adr[0] ? 2'd2 : 2'd1);
    sb.push_back(e);
    prev_wr = fwr && !mid_reset;
    prev_en = fen;
    prev_af = af;
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int d = 0; d < 4; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string tag, input string what, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk(mon_e.tag, "res_o",      bus.res_o,               mon_e.res);
      chk(mon_e.tag, "resWr_o",    16'(bus.resWr_o),        16'(mon_e.res_wr));
      chk(mon_e.tag, "aluFlags_o", 16'(bus.aluFlags_o),     16'(mon_e.alu_fl));
      chk(mon_e.tag, "flags_o",    16'(bus.flags_o),        16'(mon_e.fl));
      chk(mon_e.tag, "pcNew_o",    bus.pcNew_o,             mon_e.pc);
      chk(mon_e.tag, "badMem_o",   16'(bus.badMem_o),       16'(mon_e.bad));
      chk(mon_e.tag, "pswAddr_o",  16'(bus.pswAddr_o),      16'(mon_e.psw));
      chk(mon_e.tag, "datSel_o",   16'(bus.datSel_o),       16'(mon_e.dsel));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int          op;
    bit          bm, bc;
    logic [15:0] a, b, adr;
    bus.aluOp_i = '0; bus.byteOp_i = 1'b0; bus.bcd_i = 1'b0;
    bus.a_i = '0; bus.b_i = '0; bus.flagsWr_i = 1'b0; bus.flagsEn_i = '0;
    bus.pcSel_i = 1'b0; bus.branch_i = '0; bus.pc_i = '0; bus.adr_i = '0;

    //      tag        op  byte bcd  a         b         wr    en       psel br        pc        adr       rst
    apply("reset",    11, 0, 0, 16'h1234, 16'h5678, 1'b0, 4'b0000, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    apply("add_w",     0, 0, 0, 16'h7FFF, 16'h0001, 1'b0, 4'b0000, 0, 16'h0000, 16'h0100, 16'h0010, 0);
    apply("add_b",     0, 1, 0, 16'h00FF, 16'h0001, 1'b1, 4'b0001, 0, 16'h0000, 16'h0200, 16'h0020, 0);
    apply("rrc",      13, 0, 0, 16'h0002, 16'h0000, 1'b0, 4'b0000, 0, 16'h0000, 16'h0300, 16'h0030, 0);
    apply("rst_mid",  11, 0, 0, 16'h0000, 16'hABCD, 1'b0, 4'b0000, 0, 16'h0000, 16'h0400, 16'h0040, 1);
    apply("cmp",       5, 0, 0, 16'h0005, 16'h0005, 1'b0, 4'b0000, 0, 16'h0000, 16'h0500, 16'h0050, 0);
    apply("dadd",      4, 0, 1, 16'h0099, 16'h0001, 1'b0, 4'b0000, 0, 16'h0000, 16'h0600, 16'h0060, 0);
    apply("pc_seq",   11, 0, 0, 16'h0000, 16'h0000, 1'b0, 4'b0000, 0, 16'hFFFC, 16'h1000, 16'h0000, 0);
    apply("pc_br",    11, 0, 0, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1, 16'hFFFC, 16'h1000, 16'h0000, 0);
    apply("dec_byte", 11, 1, 0, 16'h0000, 16'h0000, 1'b0, 4'b0000, 0, 16'h0000, 16'h0000, 16'h2001, 0);
    apply("dec_word", 11, 0, 0, 16'h0000, 16'h0000, 1'b0, 4'b0000, 0, 16'h0000, 16'h0000, 16'h2001, 0);
    apply("dec_psw",  11, 0, 0, 16'h0000, 16'h0000, 1'b0, 4'b0000, 0, 16'h0000, 16'h0000, 16'hFFFD, 0);

    for (int i = 0; i < 400; i++) begin
      op = int'($urandom_range(0, 15));
      bm = 1'($urandom_range(0, 1));
      bc = 1'($urandom_range(0, 1));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if (op == 4 && bc) begin
        a = rand_bcd();
        b = rand_bcd();
      end
      adr = ($urandom_range(0, 7) == 0) ? (16'hFFFC | 16'($urandom_range(0, 1))) : 16'($urandom);
      apply("rnd", op, bm, bc, a, b, 1'($urandom_range(0, 1)), 4'($urandom),
            1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), adr,
            ($urandom_range(0, 49) == 0));
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk_i);
    #1;
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xm_exec_addr_unit.md
Name: xm_exec_addr_unit

Overview:
Execution and addressing helper for the X-Makina multi-cycle datapath. It contains:
- the word/byte ALU with a local flags register that supplies the carry-in;
- next-PC selection (sequential or branch);
- the memory address decoder (alignment check, PSW match, byte-lane select).

It sits between the register file, the memory interface and the status register.

Parameters:
- WORD, 16, datapath width in bits (must be even, at least 8).
- PSW_ADDR, 16'hFFFC, memory-mapped PSW word address (bit 0 ignored).

Ports:
- clk_i  in  1  system clock, rising edge.
- arst_i  in  1  asynchronous active-low reset.
- byteOp_i  in  1  1 = byte operation (ALU and address decode).
- aluOp_i  in  4  ALU operation code.
- bcd_i  in  1  1 = op 4 performs a decimal add.
- a_i  in  WORD  ALU operand A (destination/unary operand).
- b_i  in  WORD  ALU operand B (source).
- flagsWr_i  in  1  load the flags register.
- flagsEn_i  in  4  per-bit write mask for the flags register.
- res_o  out  WORD  ALU result, combinational.
- resWr_o  out  1  0 for CMP/BIT (result must not be written back), else 1.
- aluFlags_o  out  4  combinational flags {V,N,Z,C}; bit0 = C.
- flags_o  out  4  registered flags {V,N,Z,C}.
- pcSel_i  in  1  0 = sequential PC, 1 = branch.
- branch_i  in  WORD  signed byte offset, already sign-extended.
- pc_i  in  WORD  current PC.
- pcNew_o  out  WORD  next PC, combinational.
- adr_i  in  WORD  memory address to decode.
- badMem_o  out  1  misaligned word access.
- pswAddr_o  out  1  address hits the PSW.
- datSel_o  out  2  byte lane: 0 = word, 1 = low byte, 2 = high byte.

Behaviour:
Flags register:
- Reset clears flags_o to 4'b0000 immediately and asynchronously when arst_i = 0, at any time.
- On a clock edge with flagsWr_i = 1: flags_o[i] <= aluFlags_o[i] for every bit where flagsEn_i[i] = 1; other bits hold.
- Carry-in for the ALU is flags_o[0].
- All other outputs are combinational, with zero latency.

ALU op codes:
- 0 ADD: a+b
- 1 ADDC: a+b+cin
- 2 SUB: a+~b+1
- 3 SUBC: a+~b+cin
- 4 DADD: decimal add of a, b and cin when bcd_i = 1; binary ADDC when bcd_i = 0
- 5 CMP: same as SUB
- 6 XOR
- 7 AND
- 8 BIT: same as AND
- 9 BIC: a & ~b
- 10 BIS: a | b
- 11 MOV: b
- 12 SRA: arithmetic shift right of a
- 13 RRC: a shifted right, MSB taken from cin
- 14 SWPB: bytes of a swapped
- 15 SXT: a sign-extended from bit 7

ALU flags:
- N = result MSB; Z = (result == 0).
- Arithmetic ops: C = carry out (for SUB, C = 1 means no borrow); V = signed overflow.
- DADD: C = decimal carry out of the top digit; V = 0.
- SRA and RRC: C = a[0]; V = 0.
- Logic, MOV, SWPB, SXT: C = 0; V = 0.

Byte mode (byteOp_i = 1):
- The ALU operates on bits [7:0] only.
- res_o = {zeros, 8-bit result}.
- N, C and V are taken at bit 7 / the byte carry.
- SWPB and SXT ignore byteOp_i.

Next PC:
- pcNew_o = pc_i + 2 when pcSel_i = 0; pc_i + branch_i when pcSel_i = 1.
- Arithmetic is modulo 2^WORD (wraps).

Address decoder:
- badMem_o = ~byteOp_i & adr_i[0].
- pswAddr_o = (adr_i[WORD-1:1] == PSW_ADDR[WORD-1:1]).
- datSel_o = 0 for a word access; 1 for a byte access with adr_i[0] = 0; 2 for a byte access with adr_i[0] = 1. The value 3 is never driven.

Optional Feature:
- Macro: XM_ALU_BCD_EN.
- Defined: op 4 with bcd_i = 1 performs a per-nibble BCD add with carry. Each nibble above 9 is corrected by +6 and carries into the next nibble.
- Undefined: bcd_i is ignored and op 4 is always binary ADDC.

Decomposition:
- Shared package xm_pkg holds the op-code enum (ADD…SXT), the flag bit indices (C=0, Z=1, N=2, V=3) and the datSel encoding.
- Natural sub-module: xm_alu_core, a combinational ALU parameterized by width. It is instantiated twice, at WORD and at 8, with the output selected by byteOp_i.

Test Plan:
- ADD, word: a=0x7FFF, b=0x0001 -> res_o=0x8000, aluFlags_o=4'b1100.
- ADD, byte: a=0x00FF, b=0x0001 -> res_o=0x0000, aluFlags_o=4'b0011. With flagsWr_i=1 and flagsEn_i=4'b0001, the next edge gives flags_o=4'b0001.
- RRC with flags_o C=1, a=0x0002 -> res_o=0x8001, aluFlags_o=4'b0100.
- CMP: a=5, b=5 -> res_o=0, aluFlags_o=4'b0011, resWr_o=0.
- DADD with the macro defined, bcd_i=1, cin=0: a=0x0099, b=0x0001 -> res_o=0x0100, C=0.
- Next PC: pc_i=0x1000, pcSel_i=0 -> pcNew_o=0x1002; pcSel_i=1 with branch_i=0xFFFC -> pcNew_o=0x0FFC.
- Address decode, each checked independently:
  - byte access to 0x2001 -> datSel_o=2, badMem_o=0;
  - word access to 0x2001 -> badMem_o=1;
  - word access to 0xFFFD -> pswAddr_o=1, badMem_o=1.
- Assert arst_i=0 between clock edges -> flags_o=0 immediately.
